// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared defaults and helpers for the param_fifo block.
//            - FIFO_DEFAULT_* : default parameter values for param_fifo
//            - fifo_cnt_width : width of an occupancy counter for a depth
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 16;
    localparam int FIFO_DEFAULT_DEPTH = 8;
    localparam int FIFO_DEFAULT_AF    = 1;
    localparam int FIFO_DEFAULT_AE    = 1;

    // Occupancy ranges over 0..depth inclusive, hence depth+1 states.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Purpose  : DEPTH x WIDTH storage array with one synchronous write port and
//            one synchronous read port. The read register is cleared by rst
//            and holds its value when no read is requested.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            we_i/waddr_i/wdata_i - write enable, address, data
//            re_i/raddr_i    - read enable, address
//            rdata_o         - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset; stale words are unreachable because
    // the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a read and write to the same address in one cycle
    // returns the old word, which is what a full FIFO doing both needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_fifo
// Purpose  : Single-clock parameterised FIFO with registered read data,
//            registered write/read status and combinational occupancy flags.
//            Optional macro PARAM_FIFO_STICKY_ERR_EN makes overflow/underflow
//            sticky until err_clr; otherwise they are one-cycle pulses and
//            err_clr is ignored.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            data_in, wr_en, rd_en    - write data, write/read requests
//            err_clr                  - clears sticky error flags
//            data_out, rd_valid       - read data and its valid strobe
//            wr_ack, overflow, underflow - registered status
//            full, empty, almostfull, almostempty - occupancy flags
//            count                    - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module param_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = FIFO_DEFAULT_DEPTH,
    parameter int AF_MARGIN  = FIFO_DEFAULT_AF,
    parameter int AE_MARGIN  = FIFO_DEFAULT_AE
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [FIFO_WIDTH-1:0]                 data_in,
    input  logic                                  wr_en,
    input  logic                                  rd_en,
    input  logic                                  err_clr,
    output logic [FIFO_WIDTH-1:0]                 data_out,
    output logic                                  rd_valid,
    output logic                                  wr_ack,
    output logic                                  overflow,
    output logic                                  underflow,
    output logic                                  full,
    output logic                                  empty,
    output logic                                  almostfull,
    output logic                                  almostempty,
    output logic [fifo_cnt_width(FIFO_DEPTH)-1:0] count
);

    localparam int CW = fifo_cnt_width(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] c_DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_AF_LVL = CW'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] c_AE_LVL = CW'(AE_MARGIN);
    localparam logic [PW-1:0] c_PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q, wr_ack_q, overflow_q, underflow_q;
    logic          overflow_d, underflow_d;

    logic w_wr_acc, w_rd_acc, w_ovf_evt, w_udf_evt;

    // ------------------------------------------------------------------------
    // Acceptance: a full FIFO still takes a write when a read frees a slot in
    // the same cycle; an empty FIFO never serves a read, even alongside a write.
    // ------------------------------------------------------------------------
    assign w_wr_acc  = wr_en && (!full || rd_en);
    assign w_rd_acc  = rd_en && !empty;
    assign w_ovf_evt = wr_en && !w_wr_acc;
    assign w_udf_evt = rd_en && empty;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Explicit wrap so non-power-of-two depths work.
        if (w_wr_acc) begin
            wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_rd_acc) begin
            rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
    end

`ifdef PARAM_FIFO_STICKY_ERR_EN
    // A new event in the same cycle as err_clr wins.
    assign overflow_d  = w_ovf_evt || (overflow_q  && !err_clr);
    assign underflow_d = w_udf_evt || (underflow_q && !err_clr);
`else
    logic w_err_clr_unused;
    assign w_err_clr_unused = err_clr;
    assign overflow_d       = w_ovf_evt;
    assign underflow_d      = w_udf_evt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= w_rd_acc;
            wr_ack_q    <= w_wr_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (w_rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

    assign full        = (count_q == c_DEPTH);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= c_AF_LVL) && !full;
    assign almostempty = (count_q <= c_AE_LVL) && !empty;

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : param_fifo
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_fifo
// Purpose  : Directed self-checking bench for param_fifo at default
//            parameters. Expected values are hand-derived constants.
//            Honours PARAM_FIFO_STICKY_ERR_EN for the error-flag expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        wr_en, rd_en, err_clr;
    logic [15:0] data_out;
    logic        rd_valid, wr_ack, overflow, underflow;
    logic        full, empty, almostfull, almostempty;
    logic [3:0]  count;

    int n_checks;
    int n_fail;

`ifdef PARAM_FIFO_STICKY_ERR_EN
    localparam logic c_STICKY = 1'b1;
`else
    localparam logic c_STICKY = 1'b0;
`endif

    param_fifo u_dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        data_in  = '0;
        idle();

        // ---------------- reset state ----------------
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almostfull), 0);
        chk("rst_ae", 32'(almostempty), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_flags", 32'({rd_valid, wr_ack, overflow, underflow}), 0);

        // ---------------- fill with 1..8 ----------------
        for (int i = 1; i <= 8; i++) begin
            wr_en   = 1'b1;
            data_in = 16'(i);
            tick();
            chk($sformatf("fill_ack%0d", i), 32'(wr_ack), 1);
            chk($sformatf("fill_cnt%0d", i), 32'(count), 32'(i));
            chk($sformatf("fill_af%0d", i), 32'(almostfull), (i == 7) ? 1 : 0);
            chk($sformatf("fill_ae%0d", i), 32'(almostempty), (i == 1) ? 1 : 0);
            chk($sformatf("fill_full%0d", i), 32'(full), (i == 8) ? 1 : 0);
        end

        // ---------------- overflow on full ----------------
        data_in = 16'hDEAD;
        tick();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_ack", 32'(wr_ack), 0);
        chk("ovf_cnt", 32'(count), 8);

        // ---------------- full, simultaneous read+write ----------------
        // err_clr releases a sticky overflow; it is ignored otherwise.
        rd_en   = 1'b1;
        err_clr = 1'b1;
        data_in = 16'h00AA;
        tick();
        err_clr = 1'b0;
        chk("frw_dout", 32'(data_out), 32'h0001);
        chk("frw_vld", 32'(rd_valid), 1);
        chk("frw_ovf", 32'(overflow), 0);
        chk("frw_ack", 32'(wr_ack), 1);
        chk("frw_cnt", 32'(count), 8);

        // ---------------- drain: 2..8 then 0xAA (0xDEAD never stored) ----------
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("drn_dout%0d", i), 32'(data_out), (i == 7) ? 32'h00AA : 32'(i + 2));
            chk($sformatf("drn_vld%0d", i), 32'(rd_valid), 1);
        end
        rd_en = 1'b0;
        tick();
        chk("drn_hold", 32'(data_out), 32'h00AA);
        chk("drn_novld", 32'(rd_valid), 0);
        chk("drn_empty", 32'(empty), 1);

        // ---------------- empty, simultaneous read+write ----------------
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 16'h0055;
        tick();
        chk("erw_udf", 32'(underflow), 1);
        chk("erw_cnt", 32'(count), 1);
        chk("erw_vld", 32'(rd_valid), 0);
        chk("erw_ack", 32'(wr_ack), 1);
        wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
        chk("erw_dout", 32'(data_out), 32'h0055);
        chk("erw_vld2", 32'(rd_valid), 1);
        chk("erw_udf2", 32'(underflow), 32'(c_STICKY));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("udf_idle%0d", i), 32'(underflow), 32'(c_STICKY));
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("udf_clr", 32'(underflow), 0);
        tick();
        chk("udf_clr2", 32'(underflow), 0);

        // ---------------- 12 writes / 12 reads across pointer wrap ----------
        // Pointers both sit at 2: three lead writes, nine paired ops, three reads.
        for (int k = 0; k < 15; k++) begin
            wr_en   = (k < 12);
            rd_en   = (k >= 3);
            data_in = 16'(16'h0100 + k);
            tick();
            if (k >= 3) begin
                chk($sformatf("wrap_dout%0d", k - 3), 32'(data_out), 32'(16'h0100 + k - 3));
            end
            chk($sformatf("wrap_cnt%0d", k), 32'(count), (k < 3) ? 32'(k + 1) : (k < 12) ? 3 : 32'(14 - k));
        end
        idle();
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_udf", 32'(underflow), 0);

        // ---------------- reset mid-operation ----------------
        wr_en   = 1'b1;
        data_in = 16'h0BEE;
        tick();
        tick();
        chk("mid_cnt", 32'(count), 2);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        chk("mid_rst_cnt", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_ack", 32'(wr_ack), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("mid_udf", 32'(underflow), 1);
        chk("mid_vld", 32'(rd_valid), 0);
        chk("mid_dout", 32'(data_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_param_fifo
`default_nettype wire
